slug_port_in_buttons: RTL and testbench
=======================================

// Module: slug_port_in_buttons
// PURPOSE
// - Input-side peripheral for the slug CPU: drives slug.port_in from board buttons and switches.
// - Complements the port_out->LED path.
// - Per channel: 2-FF synchroniser and counter debouncer, then press/release edge detection.
// - Press and release events are latched in sticky flags.
// - The CPU acknowledges flags through a strobe handshake on port_out.
// - Sits in the board top (e.g. Arty) between the pins and the slug instance; runs on the core clk.
// PARAMETERS
// - N_IN, default 4: number of input channels; legal range 1..8.
// - DEBOUNCE_CYCLES, default 1000000: cycles the synced input must hold a new level before it is accepted; minimum 2.
// - CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; never overridden.
// PORTS
// - clk       in   1      core clock (PLL output)
// - rst       in   1      reset; synchronous and active-low
// - btn_raw   in   N_IN   asynchronous pin levels, active-high
// - port_out  in   32     CPU output port. [31] = ACK strobe; [15:8] = press clear mask; [23:16] = release clear mask
// - port_in   out  32     to CPU, all registered. [7:0] = debounced level; [15:8] = sticky press flags;
//                         [23:16] = sticky release flags; [31:24] = press event counter.
//                         Bits at and above N_IN in each byte read 0.
// BEHAVIOUR
// - Reset: applied when rst==0 at a clk edge.
//   - Sync flops, debounce counters, levels, flags, event counter, ack history and all port_in bits go to 0.
//   - Reset mid-debounce discards the partial count. A held button is re-qualified after reset, then reports a press.
// - Sync: btn_raw -> two flops -> s[i]. No logic between the flops.
// - Debounce FSM per channel. States: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
//   - STABLE_x: s[i] differs from the level -> go to WAIT_x' with cnt=1.
//   - WAIT_x: s[i] returns to the old level -> back to STABLE_x with cnt=0 (glitch rejected).
//   - WAIT_x, cnt==DEBOUNCE_CYCLES-1 and s[i] still new -> level flips, go to STABLE_x'; otherwise cnt++.
//   - Latency: a clean raw edge shows on port_in[i] exactly DEBOUNCE_CYCLES+3 edges later.
//     2 sync edges + DEBOUNCE_CYCLES counting edges + 1 output register edge.
// - Events: rise[i] and fall[i] are 1-cycle internal pulses on the edge where the level flips.
//   - rise sets press flag [8+i]; fall sets release flag [16+i].
//   - Event counter += popcount(rise) on the same edge; 8-bit, wraps 255->0 with no saturation.
// - ACK handshake:
//   - ack_prev registers port_out[31]. Clear fires when port_out[31]==1 && ack_prev==0; one clear per 0->1 transition.
//   - On a clear, press flags with port_out[8+i]==1 and release flags with port_out[16+i]==1 are cleared.
//   - Holding [31] high clears nothing further. The CPU must drop it before the next acknowledge.
//   - Simultaneous set and clear of the same flag: set wins, so no event is lost.
//   - The counter is never cleared by ACK; only rst zeroes it.
// - port_in is registered: flag and level updates appear one edge after the internal change.
// - No combinational path exists from port_out to port_in.
// STRUCTURE
// - Package slug_io_pkg:
//   - typedef enum logic[1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} deb_state_t
//   - Byte-lane constants: PIN_LEVEL_LSB=0, PIN_PRESS_LSB=8, PIN_RELEASE_LSB=16, PIN_COUNT_LSB=24, POUT_ACK_BIT=31.
// - Sub-module slug_debounce, instantiated N_IN times via generate.
//   - Contains one channel's sync + FSM + counter.
//   - Outputs level, rise, fall.
// - The top holds the flags, the event counter, ack edge detect and port_in packing.
// TESTING (bench parameters: DEBOUNCE_CYCLES=4, N_IN=4)
// 1. Reset: rst=0 for 3 edges with btn_raw=4'hF -> port_in==0 throughout.
//    Release rst -> press flags 0x0F and counter 4 exactly 7 edges later.
// 2. Clean press: btn_raw[0] 0->1 and held -> port_in[0]==1, port_in[8]==1, [31:24]==1, all at edge 7.
//    No earlier change.
// 3. Bounce: btn_raw[1] high for 3 cycles, low 1, then high -> no press after the first 3 cycles.
//    Level rises 7 edges after the last 0->1 transition; counter increments once.
// 4. ACK:
//    - Press flags 0x05 set; port_out=32'h8000_0100 for 5 cycles -> flags go to 0x04 one edge after the 0->1 transition.
//    - Bit 10 is unaffected; a second clear needs port_out[31] 0 then 1.
// 5. Set-over-clear: ack on bit 2 in the same cycle as a new ch2 rise -> port_in[10] stays 1.
// 6. Counter wrap: 256 presses on ch3 -> [31:24] returns to 0x00.
//    Release flag [19] is set after each release until acked.

Source files
------------

// File: rtl/slug_io_pkg.sv
// Shared types and port_in/port_out bit-lane positions for the slug button input port.
package slug_io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

  localparam int PIN_LEVEL_LSB      = 0;
  localparam int PIN_PRESS_LSB      = 8;
  localparam int PIN_RELEASE_LSB    = 16;
  localparam int PIN_COUNT_LSB      = 24;
  localparam int POUT_PRESS_CLR_LSB = 8;
  localparam int POUT_REL_CLR_LSB   = 16;
  localparam int POUT_ACK_BIT       = 31;

endpackage

// File: rtl/slug_debounce.sv
// One button channel: two-flop synchroniser, counter debouncer and edge pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STABLE_LO | accepted level is 0, synced input agrees
// WAIT_HI   | synced input went 1, counting how long it stays there
// STABLE_HI | accepted level is 1, synced input agrees
// WAIT_LO   | synced input went 0, counting how long it stays there
module slug_debounce
  import slug_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Plain two-flop synchroniser; nothing may sit between the flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state and hold counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; rise/fall pulse on the same edge the accepted level flips.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_o  = 1'b0;
    fall_o  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          fall_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = (state_q == STABLE_HI) || (state_q == WAIT_LO);

endmodule

// File: rtl/slug_port_in_buttons.sv
// Button/switch input port for the slug CPU: debounced levels, sticky
// press/release flags acknowledged over port_out, and a press event counter.
module slug_port_in_buttons
  import slug_io_pkg::*;
#(
  parameter int N_IN            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] btn_raw,
  input  logic [31:0]     port_out,
  output logic [31:0]     port_in
);

  logic [N_IN-1:0] level, rise, fall;
  logic [N_IN-1:0] press_q, press_d;
  logic [N_IN-1:0] rel_q, rel_d;
  logic [7:0]      evt_q, evt_d, evt_inc;
  logic            ack_prev_q;
  logic            ack_clr;
  logic [31:0]     port_in_q, pin_d;
  logic            unused_pout;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    slug_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  // Only some port_out bits carry meaning here; the rest are deliberately ignored.
  assign unused_pout = ^port_out;

  // One clear per rising edge of the ACK strobe.
  assign ack_clr = port_out[POUT_ACK_BIT] & ~ack_prev_q;

  // Flag update: clear first, then OR in new events so a same-cycle event survives.
  always_comb begin
    press_d = press_q;
    rel_d   = rel_q;
    if (ack_clr) begin
      press_d = press_q & ~port_out[POUT_PRESS_CLR_LSB +: N_IN];
      rel_d   = rel_q & ~port_out[POUT_REL_CLR_LSB +: N_IN];
    end
    press_d = press_d | rise;
    rel_d   = rel_d | fall;
    evt_inc = '0;
    for (int i = 0; i < N_IN; i++) begin
      evt_inc = evt_inc + 8'(rise[i]);
    end
    evt_d = evt_q + evt_inc;
  end

  // Pack the CPU-visible word; unused channel bits stay 0.
  always_comb begin
    pin_d = '0;
    pin_d[PIN_LEVEL_LSB +: N_IN]   = level;
    pin_d[PIN_PRESS_LSB +: N_IN]   = press_q;
    pin_d[PIN_RELEASE_LSB +: N_IN] = rel_q;
    pin_d[PIN_COUNT_LSB +: 8]      = evt_q;
  end

  // Flags, counter, ack history and the registered port_in word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      press_q    <= '0;
      rel_q      <= '0;
      evt_q      <= '0;
      ack_prev_q <= 1'b0;
      port_in_q  <= '0;
    end else begin
      press_q    <= press_d;
      rel_q      <= rel_d;
      evt_q      <= evt_d;
      ack_prev_q <= port_out[POUT_ACK_BIT];
      port_in_q  <= pin_d;
    end
  end

  assign port_in = port_in_q;

endmodule

// File: tb/tb_slug_port_in_buttons.sv
// Directed bench for slug_port_in_buttons with DEBOUNCE_CYCLES=4, N_IN=4.
module tb_slug_port_in_buttons;

  logic        clk;
  logic        rst;
  logic [3:0]  btn_raw;
  logic [31:0] port_out;
  logic [31:0] port_in;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        rst;
    logic [3:0]  btn;
    logic [31:0] pout;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  slug_port_in_buttons #(
    .N_IN           (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .port_out(port_out),
    .port_in (port_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic add_vec(input logic r, input logic [3:0] b, input logic [31:0] p,
                         input logic [31:0] e);
    vec_t v;
    v.rst  = r;
    v.btn  = b;
    v.pout = p;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  initial begin
    rst      = 1'b0;
    btn_raw  = 4'h0;
    port_out = 32'h0;

    // Reset held with all buttons high, then released: flags appear 7 edges later.
    for (int i = 0; i < 3; i++) add_vec(1'b0, 4'hF, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) add_vec(1'b1, 4'hF, 32'h0, 32'h0);
    add_vec(1'b1, 4'hF, 32'h0, 32'h0400_0F0F);
    // Reset again with buttons low.
    for (int i = 0; i < 2; i++) add_vec(1'b0, 4'h0, 32'h0, 32'h0);
    // Clean press on channel 0.
    for (int i = 0; i < 6; i++) add_vec(1'b1, 4'h1, 32'h0, 32'h0);
    add_vec(1'b1, 4'h1, 32'h0, 32'h0100_0101);
    add_vec(1'b1, 4'h1, 32'h0, 32'h0100_0101);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      btn_raw  = vecs[i].btn;
      port_out = vecs[i].pout;
      step(1);
      check($sformatf("vec%0d", i), port_in, vecs[i].exp);
    end

    // Bounce on channel 1: high 3, low 1, then high.
    for (int e = 1; e <= 10; e++) begin
      btn_raw = (e == 4) ? 4'b0001 : 4'b0011;
      step(1);
      check($sformatf("bounce_e%0d", e), port_in, 32'h0100_0101);
    end
    step(1);
    check("bounce_e11", port_in, 32'h0200_0303);

    // ACK: press flags 0x05, clear bit 8 only.
    rst = 1'b0; btn_raw = 4'h0;
    step(2);
    check("ack_rst", port_in, 32'h0);
    rst = 1'b1; btn_raw = 4'b0101;
    step(6);
    check("ack_pre", port_in, 32'h0);
    step(1);
    check("ack_set", port_in, 32'h0200_0505);
    port_out = 32'h8000_0100;
    step(1);
    check("ack_e1", {24'h0, port_in[15:8]}, 32'h05);
    step(1);
    check("ack_e2", {24'h0, port_in[15:8]}, 32'h04);
    step(3);
    check("ack_hold", port_in, 32'h0200_0405);
    port_out = 32'h8000_0400;
    step(2);
    check("ack_no_reclr", {24'h0, port_in[15:8]}, 32'h04);
    port_out = 32'h0;
    step(1);
    port_out = 32'h8000_0400;
    step(2);
    check("ack_second", {24'h0, port_in[15:8]}, 32'h00);
    port_out = 32'h0;

    // Set-over-clear on channel 2.
    btn_raw = 4'b0001;
    step(7);
    check("soc_release", port_in, 32'h0204_0001);
    btn_raw = 4'b0101;
    step(5);
    port_out = 32'h8000_0400;
    step(1);
    port_out = 32'h0;
    step(1);
    check("soc_bit10", {31'h0, port_in[10]}, 32'h1);
    check("soc_word", port_in, 32'h0304_0405);
    port_out = 32'h8004_0000;
    step(1);
    port_out = 32'h0;
    step(1);
    check("rel_clr", {24'h0, port_in[23:16]}, 32'h00);

    // Counter wrap with 256 presses on channel 3.
    rst = 1'b0; btn_raw = 4'h0;
    step(2);
    rst = 1'b1;
    for (int k = 0; k < 256; k++) begin
      btn_raw = 4'b1000;
      step(8);
      check($sformatf("wrap_cnt%0d", k), {24'h0, port_in[31:24]}, 32'((k + 1) % 256));
      check($sformatf("wrap_lvl%0d", k), {28'h0, port_in[3:0]}, 32'h8);
      btn_raw = 4'b0000;
      step(8);
      check($sformatf("wrap_rel%0d", k), {31'h0, port_in[19]}, 32'h1);
      port_out = 32'h8008_0000;
      step(1);
      port_out = 32'h0;
      step(1);
      check($sformatf("wrap_ack%0d", k), {31'h0, port_in[19]}, 32'h0);
    end
    check("wrap_final", port_in, 32'h0000_0800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
